// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN_DEF   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN_DEF-1:0]   data;
  } wb_entry_t;

  // x0 is hardwired; nothing targeting it may reach the regfile or scoreboard.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] rd);
    return rd != '0;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_wb_pending_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
module wb_pending_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_entry,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between pipeline writeback and long-latency results.
// Optional starvation guard enabled by defining RF_WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbValid,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic [XLEN-1:0]       wbData,
  input  logic                  luValid,
  output logic                  luReady,
  input  logic [REG_ADDR_W-1:0] luRd,
  input  logic [XLEN-1:0]       luData,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  input  logic [REG_ADDR_W-1:0] rs1Addr,
  input  logic [REG_ADDR_W-1:0] rs2Addr,
  output logic                  rs1Busy,
  output logic                  rs2Busy,
  output logic                  issueRdBusy,
  output logic                  stallReq,
  output logic                  rfWrEn,
  output logic [REG_ADDR_W-1:0] rfWrAddr,
  output logic [XLEN-1:0]       rfWrData
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } entry_t;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  entry_t              head, lu_entry;
  logic                full, empty, push, commit;
  logic [NUM_REGS-1:0] pending, pending_nxt;

  assign luReady  = !full;
  assign push     = luValid && !full;
  assign commit   = !rst && !wbValid && !empty;
  assign lu_entry = '{rd: luRd, data: luData};

  wb_pending_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (lu_entry),
    .pop        (commit),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  // Pipeline writeback always wins; the FIFO only fills the gaps.
  always_comb begin
    rfWrEn   = 1'b0;
    rfWrAddr = '0;
    rfWrData = '0;
    if (wbValid) begin
      rfWrEn   = writes_reg(wbRd);
      rfWrAddr = wbRd;
      rfWrData = wbData;
    end else if (!empty) begin
      rfWrEn   = writes_reg(head.rd);
      rfWrAddr = head.rd;
      rfWrData = head.data;
    end
    if (rst) rfWrEn = 1'b0;
  end

  // A new issue to the register being retired must keep it pending.
  always_comb begin
    pending_nxt = pending;
    if (commit) pending_nxt[head.rd] = 1'b0;
    if (issueValid && writes_reg(issueRd)) pending_nxt[issueRd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign rs1Busy     = pending[rs1Addr] && writes_reg(rs1Addr);
  assign rs2Busy     = pending[rs2Addr] && writes_reg(rs2Addr);
  assign issueRdBusy = pending[issueRd] && writes_reg(issueRd);

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // Non-empty without a commit means writeback held the port this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stallReq   <= 1'b0;
    end else begin
      stallReq <= 1'b0;
      if (empty || commit) begin
        starve_cnt <= '0;
      end else if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) begin
        starve_cnt <= '0;
        stallReq   <= 1'b1;
      end else begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign stallReq = 1'b0;
`endif

`ifndef SYNTHESIS
  a_lu_overflow: assert property (@(posedge clk) disable iff (rst) !(luValid && !luReady));
  a_wb_pending:  assert property (@(posedge clk) disable iff (rst) !(wbValid && pending[wbRd]));
  a_issue_waw:   assert property (@(posedge clk) disable iff (rst) !(issueValid && issueRdBusy));
`ifdef RF_WB_STARVE_GUARD_EN
  a_stall_honor: assert property (@(posedge clk) disable iff (rst) !(stallReq && wbValid));
`endif
`endif
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two requesters.
- In-order pipeline writeback: already selected by the writeback mux.
- Long-latency unit: late loads / mul-div.
Buffers long-latency results in a small FIFO and keeps a per-register pending scoreboard so decode can stall on hazards. Sits between the writeback mux output and the regfile write port.

Parameters:
XLEN, 32, data width
FIFO_DEPTH, 2, long-latency result buffer entries (power of 2, >=2)
STARVE_LIMIT, 4, consecutive blocked cycles before the pipeline is asked to bubble

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wbValid  in  1  pipeline writeback request this cycle
wbRd  in  5  pipeline destination register
wbData  in  XLEN  pipeline writeback data (writeback mux output)
luValid  in  1  long-latency result valid
luReady  out  1  FIFO can accept a result
luRd  in  5  long-latency destination register
luData  in  XLEN  long-latency result data
issueValid  in  1  long-latency op issued this cycle
issueRd  in  5  destination of issued op
rs1Addr  in  5  decode source 1
rs2Addr  in  5  decode source 2
rs1Busy  out  1  rs1 has a pending long-latency write
rs2Busy  out  1  rs2 has a pending long-latency write
issueRdBusy  out  1  issueRd already pending (WAW); decode must stall
stallReq  out  1  request one pipeline writeback bubble
rfWrEn  out  1  regfile write enable
rfWrAddr  out  5  regfile write address
rfWrData  out  XLEN  regfile write data

Behaviour:
- Reset values: all outputs 0 except luReady=1. FIFO empty, pending[31:0]=0, starveCnt=0, stallReq=0.
- Priority: wbValid always wins, zero latency. rfWrEn/Addr/Data are combinational from wb* when wbValid=1.
- If wbValid=0 and the FIFO is non-empty, the FIFO head drives the port and is popped at the clock edge.
- An entry accepted at edge N can commit no earlier than cycle N+1. The FIFO never bypasses straight to the port.
- luReady = !full, combinational; does not depend on the same-cycle pop. Push occurs when luValid && luReady.
- luValid while luReady=0 is a protocol error: flag with a simulation assertion, result dropped.
- rd=0 from either source: rfWrEn forced 0. A FIFO entry with rd=0 still pops in its slot.
- Scoreboard:
  - pending[issueRd] set at edge when issueValid && issueRd!=0.
  - pending[head.rd] cleared at edge when the head commits.
  - Set and clear of the same rd in one cycle: set wins.
  - A FIFO entry remains pending until written.
- Hazard outputs, combinational:
  - rsNBusy = pending[rsNAddr] && rsNAddr!=0.
  - issueRdBusy = pending[issueRd] && issueRd!=0.
  - No forwarding from a committing write is implied.
- Protocol asserts (simulation only):
  - wbValid with pending[wbRd]=1 is illegal.
  - issueValid with issueRdBusy=1 is illegal.
- Counters are FIFO_DEPTH-bounded. Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
- Reset mid-operation: FIFO contents, scoreboard and starvation state are discarded immediately. No write occurs in the reset cycle (rfWrEn=0 while rst=1).

Optional Feature:
RF_WB_STARVE_GUARD_EN.
- Defined:
  - starveCnt increments each cycle the FIFO is non-empty and wbValid=1.
  - starveCnt resets to 0 on a head commit or when the FIFO is empty.
  - When starveCnt reaches STARVE_LIMIT, stallReq is registered high for exactly one cycle and starveCnt resets.
  - Upstream must hold wbValid=0 that cycle. If wbValid=1 anyway, wb still wins and an assertion fires.
- Undefined: stallReq tied 0, no counter. The FIFO drains only in natural wb bubbles.

Decomposition:
- Shared package: WbEntry struct {rd[4:0], data[XLEN-1:0]}, REG_ADDR_W=5, NUM_REGS=32.
- Sub-module wb_pending_fifo: sync FIFO of WbEntry with push/pop/full/empty/head. The arbiter holds the scoreboard, priority logic and starvation counter.

Test Plan:
- Reset, then wbValid=1 rd=5 data=0xDEADBEEF -> same-cycle rfWrEn=1, addr=5, data=0xDEADBEEF; pending unchanged.
- Issue rd=7; 3 cycles later lu push rd=7 data=0x12345678 with wbValid=0 -> rs1Addr=7 gives rs1Busy=1 from cycle after issue; write occurs cycle after push; rs1Busy=0 the cycle after the write.
- wbValid=1 continuously and two lu results pushed -> luReady=0 after second push. With guard: stallReq=1 after 4 blocked cycles; head commits in the bubble; luReady returns 1.
- Issue rd=3 and head commit rd=3 in the same cycle -> pending[3] stays 1.
- lu push rd=0 data=0xFFFFFFFF -> pops with rfWrEn=0; x0 scoreboard never set.
- Assert rst with two entries queued and pending[9]=1 -> next cycle FIFO empty, luReady=1, rs1Busy for rs1Addr=9 is 0, no regfile write.
